// File: rtl/pluto_pwm_pkg.sv
// Shared definitions for the pluto PWM bank: channel/control word bit positions,
// the decoded channel word layout and the dither compare-value helper.
package pluto_pwm_pkg;

  localparam int CH_SIGN   = 15;
  localparam int CH_DITHER = 14;
  localparam int CH_DINV   = 13;
  localparam int CH_UINV   = 12;

  localparam int CTL_KICK  = 0;
  localparam int CTL_FDIS  = 1;

  // Widest supported counter; narrower configurations zero-extend into it.
  localparam int CW_MAX    = 12;

  typedef struct packed {
    logic              sign;
    logic              dither;
    logic              dinv;
    logic              uinv;
    logic [CW_MAX-1:0] duty;
  } chan_word_t;

  function automatic chan_word_t decode_chan_word(input logic [15:0] data, input int cw);
    chan_word_t w;
    w.sign   = data[CH_SIGN];
    w.dither = data[CH_DITHER];
    w.dinv   = data[CH_DINV];
    w.uinv   = data[CH_UINV];
    w.duty   = '0;
    for (int i = 0; i < CW_MAX; i++) begin
      if (i < cw) w.duty[i] = data[i];
    end
    return w;
  endfunction

  // Keeps c[dlsb-1:0] in place and bit-reverses c[cw-1:dlsb].
  function automatic logic [CW_MAX-1:0] bitrev_dither(input logic [CW_MAX-1:0] c,
                                                      input int cw, input int dlsb);
    logic [CW_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < CW_MAX; i++) begin
      if (i < dlsb)    r[i] = c[i];
      else if (i < cw) r[i] = c[cw - 1 - i + dlsb];
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active word, compare against the shared counter and output register.
// Active word loads on the bank's period wrap; pins follow the compare by one cycle.
module pwm_channel
  import pluto_pwm_pkg::*;
#(
  parameter int CW   = 11,
  parameter int DLSB = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_en,
  input  logic [15:0]   i_wr_data,
  input  logic          i_load,
  input  logic [CW-1:0] i_cnt,
  output logic          o_up,
  output logic          o_down
);

  chan_word_t        r_shadow;
  chan_word_t        r_active;
  logic              r_up;
  logic              r_down;

  logic [CW_MAX-1:0] w_cnt_ext;
  logic [CW_MAX-1:0] w_rev;
  logic [CW_MAX-1:0] w_cmp;
  logic              w_act;

  always_comb begin
    w_cnt_ext = CW_MAX'(i_cnt);
    w_rev     = bitrev_dither(w_cnt_ext, CW, DLSB);
    w_cmp     = r_active.dither ? w_rev : w_cnt_ext;
    // Duty above top never loses the compare, giving a solid 100 %.
    w_act     = r_active.duty > w_cmp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_up     <= 1'b0;
      r_down   <= 1'b0;
    end else begin
      if (i_wr_en) r_shadow <= decode_chan_word(i_wr_data, CW);
      if (i_load)  r_active <= r_shadow;
      r_up   <= r_active.uinv ^ (~r_active.sign & w_act);
      r_down <= r_active.dinv ^ (r_active.sign & w_act);
    end
  end

  assign o_up   = r_up;
  assign o_down = r_down;

endmodule

// File: rtl/pwm_servo_bank.sv
// N-channel PWM bank with programmable period, wrap-synchronous register updates and a period watchdog.
// Register writes reach the pins at the next wrap + 1 cycle; there is no backpressure on writes.
module pwm_servo_bank
  import pluto_pwm_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CW          = 11,
  parameter int DLSB        = 4,
  parameter int WDT_PERIODS = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [4:0]     wr_addr,
  input  logic [15:0]    wr_data,
  output logic [NCH-1:0] up,
  output logic [NCH-1:0] down,
  output logic           at_top,
  output logic           oe
);

  localparam logic [CW-1:0] TOP_RST  = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [7:0]    WDT_LOAD = 8'(WDT_PERIODS);

  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  r_top_act;
  logic [CW-1:0]  r_top_shd;
  logic [7:0]     r_wdt_cnt;
  logic           r_oe;

  logic           w_at_top;
  logic           w_top_we;
  logic           w_ctl_we;
  logic           w_kick;
  logic           w_fdis;
  logic [NCH-1:0] w_ch_we;

  always_comb begin
    w_at_top = (r_cnt == r_top_act);
    w_top_we = wr_en && (wr_addr == 5'(NCH));
    w_ctl_we = wr_en && (wr_addr == 5'(NCH + 1));
    w_fdis   = w_ctl_we && wr_data[CTL_FDIS];
    w_kick   = w_ctl_we && wr_data[CTL_KICK] && !wr_data[CTL_FDIS];
    w_ch_we  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_ch_we[i] = wr_en && (wr_addr == 5'(i));
    end
  end

  // Top is only swapped at wrap, so a smaller new top cannot strand the counter above it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_top_act <= TOP_RST;
      r_top_shd <= TOP_RST;
    end else begin
      if (w_top_we) r_top_shd <= wr_data[CW-1:0];
      if (w_at_top) begin
        r_cnt     <= '0;
        r_top_act <= r_top_shd;
      end else begin
        r_cnt     <= r_cnt + 1'b1;
      end
    end
  end

  // A kick on a wrap cycle reloads rather than decrements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdt_cnt <= '0;
      r_oe      <= 1'b0;
    end else if (w_fdis) begin
      r_wdt_cnt <= '0;
      r_oe      <= 1'b0;
    end else if (w_kick) begin
      r_wdt_cnt <= WDT_LOAD;
      r_oe      <= (WDT_LOAD != 8'd0);
    end else if (w_at_top && (r_wdt_cnt != 8'd0)) begin
      r_wdt_cnt <= r_wdt_cnt - 8'd1;
      if (r_wdt_cnt == 8'd1) r_oe <= 1'b0;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_channel #(
      .CW   (CW),
      .DLSB (DLSB)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_ch_we[g]),
      .i_wr_data (wr_data),
      .i_load    (w_at_top),
      .i_cnt     (r_cnt),
      .o_up      (up[g]),
      .o_down    (down[g])
    );
  end

  assign at_top = w_at_top;
  assign oe     = r_oe;

endmodule

// File: tb/tb_pwm_servo_bank.sv
// Directed bench for pwm_servo_bank (NCH=4, CW=11, DLSB=4, WDT_PERIODS=3):
// a table of period/duty/mode vectors plus hand sequences for wrap, watchdog, dither and reset.
module tb_pwm_servo_bank;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  up;
  logic [3:0]  down;
  logic        at_top;
  logic        oe;

  int checks;
  int errors;

  localparam logic [4:0] A_TOP = 5'd4;
  localparam logic [4:0] A_CTL = 5'd5;

  typedef struct {
    int top;
    int duty;
    bit sign;
    bit uinv;
    bit dinv;
    int per;
    int hu;
    int hd;
  } vec_t;

  vec_t vecs[9];

  pwm_servo_bank #(
    .NCH         (4),
    .CW          (11),
    .DLSB        (4),
    .WDT_PERIODS (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .up      (up),
    .down    (down),
    .at_top  (at_top),
    .oe      (oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] cword(input bit s, input bit d, input bit di, input bit ui,
                                        input int duty);
    return {s, d, di, ui, 1'b0, 11'(duty)};
  endfunction

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_top(input string nm);
    for (int i = 0; i < 5000; i++) begin
      if (at_top) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL %s: got no at_top in 5000 cycles expected one", nm);
  endtask

  // Called at the negedge where cnt is 0; ends at the negedge where cnt is 0 again.
  task automatic measure(input int ch, output int per, output int hu, output int hd,
                         output int maxrun);
    bit pa;
    int run;
    per = 0; hu = 0; hd = 0; maxrun = 0; run = 0;
    for (int i = 0; i < 5000; i++) begin
      pa = at_top;
      @(negedge clk);
      per++;
      if (up[ch]) begin
        hu++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (down[ch]) hd++;
      if (pa) break;
    end
  endtask

  task automatic cycles_to_top(output int n, output int uph);
    n = 0; uph = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      n++;
      if (up[0]) uph++;
      if (at_top) return;
    end
  endtask

  task automatic watch_wdt(input string nm);
    int  n;
    bit  last;
    n = 0; last = 1'b0;
    chk({nm, "_rise"}, int'(oe), 1);
    for (int i = 0; i < 1000; i++) begin
      if (!oe) break;
      last = at_top;
      if (at_top) n++;
      @(negedge clk);
    end
    chk({nm, "_pulses"}, n, 3);
    chk({nm, "_fall_after_top"}, int'(last), 1);
  endtask

  initial begin
    int per, hu, hd, mr, n, uph;
    checks = 0; errors = 0;

    vecs[0] = '{top: 9,  duty: 3,    sign: 0, uinv: 0, dinv: 0, per: 10, hu: 3,  hd: 0};
    vecs[1] = '{top: 9,  duty: 0,    sign: 0, uinv: 0, dinv: 0, per: 10, hu: 0,  hd: 0};
    vecs[2] = '{top: 9,  duty: 10,   sign: 0, uinv: 0, dinv: 0, per: 10, hu: 10, hd: 0};
    vecs[3] = '{top: 9,  duty: 3,    sign: 1, uinv: 0, dinv: 0, per: 10, hu: 0,  hd: 3};
    vecs[4] = '{top: 9,  duty: 3,    sign: 0, uinv: 1, dinv: 0, per: 10, hu: 7,  hd: 0};
    vecs[5] = '{top: 9,  duty: 3,    sign: 0, uinv: 0, dinv: 1, per: 10, hu: 3,  hd: 10};
    vecs[6] = '{top: 19, duty: 5,    sign: 1, uinv: 1, dinv: 0, per: 20, hu: 20, hd: 5};
    vecs[7] = '{top: 0,  duty: 1,    sign: 0, uinv: 0, dinv: 0, per: 1,  hu: 1,  hd: 0};
    vecs[8] = '{top: 63, duty: 2047, sign: 0, uinv: 0, dinv: 0, per: 64, hu: 64, hd: 0};

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_up", int'(up), 0);
    chk("rst_down", int'(down), 0);
    chk("rst_at_top", int'(at_top), 0);
    chk("rst_oe", int'(oe), 0);
    reset = 1'b0;
    cycles_to_top(n, uph);
    chk("rst_first_top", n, 2046);
    chk("rst_up_idle", uph, 0);

    for (int v = 0; v < 9; v++) begin
      wr(A_TOP, 16'(vecs[v].top));
      wr(5'd0, cword(vecs[v].sign, 1'b0, vecs[v].dinv, vecs[v].uinv, vecs[v].duty));
      wait_top($sformatf("vec%0d_wrap", v));
      @(negedge clk);
      measure(0, per, hu, hd, mr);
      chk($sformatf("vec%0d_period", v), per, vecs[v].per);
      chk($sformatf("vec%0d_up_high", v), hu, vecs[v].hu);
      chk($sformatf("vec%0d_down_high", v), hd, vecs[v].hd);
    end

    wr(A_TOP, 16'd9);
    wr(5'd1, cword(0, 0, 0, 0, 2));
    wait_top("ch1_setup");
    @(negedge clk);
    wait_top("ch1_top");
    wr(5'd1, cword(0, 0, 0, 0, 6));
    measure(1, per, hu, hd, mr);
    chk("ch1_old_duty", hu, 2);
    measure(1, per, hu, hd, mr);
    chk("ch1_new_duty", hu, 6);

    wr(A_CTL, 16'h0001);
    watch_wdt("wdt_single");
    wr(A_CTL, 16'h0001);
    wait_top("wdt_kick_top");
    wr(A_CTL, 16'h0001);
    watch_wdt("wdt_kick_on_top");
    wr(A_CTL, 16'h0001);
    repeat (4) @(negedge clk);
    chk("wdt_before_fdis", int'(oe), 1);
    wr(A_CTL, 16'h0002);
    chk("wdt_fdis", int'(oe), 0);
    wr(A_CTL, 16'h0001);
    chk("wdt_rekick", int'(oe), 1);
    wr(A_CTL, 16'h0003);
    chk("wdt_fdis_wins", int'(oe), 0);

    wr(A_TOP, 16'd2046);
    wait_top("shrink_setup");
    @(negedge clk);
    repeat (500) @(negedge clk);
    wr(A_TOP, 16'd99);
    cycles_to_top(n, uph);
    chk("shrink_finish", n, 1545);
    @(negedge clk);
    measure(0, per, hu, hd, mr);
    chk("shrink_period", per, 100);

    wr(A_TOP, 16'd2046);
    wr(5'd2, cword(0, 1, 0, 0, 1024));
    wait_top("dither_wrap");
    @(negedge clk);
    measure(2, per, hu, hd, mr);
    chk("dither_period", per, 2047);
    chk("dither_high", hu, 1024);
    chk("dither_max_run", mr, 16);

    wr(5'd0, cword(0, 0, 0, 1, 0));
    wr(A_CTL, 16'h0001);
    wait_top("areset_setup");
    @(negedge clk);
    repeat (37) @(negedge clk);
    chk("areset_pre_up", int'(up[0]), 1);
    chk("areset_pre_oe", int'(oe), 1);
    #3 reset = 1'b1;
    #1;
    chk("areset_up", int'(up), 0);
    chk("areset_down", int'(down), 0);
    chk("areset_oe", int'(oe), 0);
    chk("areset_at_top", int'(at_top), 0);
    @(negedge clk);
    reset = 1'b0;
    cycles_to_top(n, uph);
    chk("areset_first_top", n, 2046);
    chk("areset_up_idle", uph, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
